// File: rtl/nibble_serial_logic_unit_if.sv
// Start/busy/done handshake and operand/result bus between the ALU control
// sequencer (master) and the nibble-serial logic unit (slave).
interface nibble_serial_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, out, zero
  );
endinterface

// File: rtl/nibble_serial_logic_unit.sv
// Multi-cycle bitwise logic unit: latches operands and opcode, then computes
// the result one SLICE-bit slice per clock (LSB first) through a shared stage.
module nibble_serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  nibble_serial_logic_unit_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             zero_q, zero_d;
  logic             accept;

  // The single shared slice stage; NOR stays within the slice, no carries.
  function automatic logic [SLICE-1:0] slice_fn(op_e f, logic [SLICE-1:0] x,
                                                logic [SLICE-1:0] y);
    unique case (f)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Start is only honoured when no slices are in flight.
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned and a latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    idx_d   = idx_q;
    zero_d  = zero_q;

    if (accept) begin
      state_d = RUN;
      op_d    = op_e'(bus.op);
      a_d     = bus.a;
      b_d     = bus.b;
      out_d   = '0;
      idx_d   = '0;
      zero_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          out_d[idx_q*SLICE +: SLICE] = slice_fn(op_q, a_q[idx_q*SLICE +: SLICE],
                                                 b_q[idx_q*SLICE +: SLICE]);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            zero_d  = (out_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end
  end

  // NOTE: all state, including operand latches, is reset so that no partial
  // result or stale operand survives an asynchronous reset mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_logic_unit.sv
// Directed self-checking bench for nibble_serial_logic_unit: latency, handshake,
// opcode results, input/start robustness, back-to-back accept and async reset.
module tb_nibble_serial_logic_unit;

  localparam int WIDTH  = 32;
  localparam int NSLICE = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  nibble_serial_logic_unit_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_logic_unit #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [WIDTH-1:0] exp_out,
                            input logic exp_zero);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd0);
    check({tag, ".out"},  bus.out, exp_out);
    check({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
  endtask

  // Drive operands with start high; returns at the negedge after the accept
  // edge, i.e. in the first RUN cycle.
  task automatic launch(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called in the first RUN cycle; checks busy for NSLICE cycles, then the
  // done cycle. With chain set, start is held in the done cycle.
  task automatic finish(input string tag, input logic [WIDTH-1:0] exp_out,
                        input logic exp_zero, input bit disturb, input bit chain,
                        input logic [1:0] nop, input logic [WIDTH-1:0] na,
                        input logic [WIDTH-1:0] nb);
    for (int k = 1; k <= NSLICE; k++) begin
      check($sformatf("%s.busy_c%0d", tag, k), 32'(bus.busy), 32'd1);
      check($sformatf("%s.done_c%0d", tag, k), 32'(bus.done), 32'd0);
      if (disturb) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".out"}, bus.out, exp_out);
    check({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
    if (chain) begin
      launch(nop, na, nb);
    end else begin
      @(negedge clk);
      check_idle({tag, ".hold"}, exp_out, exp_zero);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    // Reset held three cycles, then ten idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("rst_c%0d", i), 32'h0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle_c%0d", i), 32'h0, 1'b0);
    end

    launch(2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
    finish("and", 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);

    launch(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
    finish("nor", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00, '0, '0);

    launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0000);
    finish("or", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);

    // Operands, opcode and start churn during RUN; only one done follows.
    launch(2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    finish("xor_robust", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);

    // Back-to-back: second op accepted in the done cycle of the first.
    launch(2'b00, 32'h1234_5678, 32'hFFFF_0000);
    finish("b2b_first", 32'h1234_0000, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1, 32'h1);
    finish("b2b_second", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'b00, '0, '0);

    // Asynchronous reset at slice index 4, away from any clock edge.
    launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0000);
    repeat (4) @(negedge clk);
    check("midrst.busy_pre", 32'(bus.busy), 32'd1);
    check("midrst.out_partial", bus.out, 32'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1 check_idle("midrst.async", 32'h0, 1'b0);
    @(negedge clk);
    check_idle("midrst.held", 32'h0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("midrst.release", 32'h0, 1'b0);

    launch(2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    finish("after_rst", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
